// File: rtl/mig_pkg.sv
// Shared operand type, FSM state encoding and operand index-space layout
// for the MIG truth-table engine.
package mig_pkg;

  localparam int OP_IDX_MAX = 8;
  localparam int CONST_IDX  = 0;
  localparam int IN_BASE    = 1;

  // Index field is sized for the largest supported index space; narrower
  // configurations keep the upper bits at zero.
  typedef struct packed {
    logic                  comp;
    logic [OP_IDX_MAX-1:0] idx;
  } mig_op_t;

  typedef enum logic [1:0] {IDLE, EVAL, EMIT} mig_state_e;

  function automatic int node_base(input int num_in);
    return IN_BASE + num_in;
  endfunction

endpackage

// File: rtl/mig_maj3.sv
// Three-input majority on optionally complemented operands, purely combinational.
module mig_maj3 (
  input  logic [2:0] val,
  input  logic [2:0] comp,
  output logic       y
);

  logic [2:0] v;

  assign v = val ^ comp;
  assign y = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);

endmodule

// File: rtl/mig_tt_engine.sv
// Programmable MIG evaluator: sweeps all input minterms and streams the truth table.
// Optional MIG_TT_ONSET_EN adds the tt_ones / tt_const onset summary outputs.
//
// state | meaning
// IDLE  | waiting for start, config writes accepted
// EVAL  | evaluating node node_ptr for the current minterm
// EMIT  | presenting tt_bit for the current minterm
module mig_tt_engine
  import mig_pkg::*;
#(
  parameter int NUM_IN    = 7,
  parameter int MAX_NODES = 8,
  parameter int IDX_W     = $clog2(1 + NUM_IN + MAX_NODES),
  parameter int OP_W      = IDX_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [$clog2(MAX_NODES)-1:0]   cfg_node,
  input  logic [OP_W-1:0]                cfg_op0,
  input  logic [OP_W-1:0]                cfg_op1,
  input  logic [OP_W-1:0]                cfg_op2,
  output logic                           cfg_err,
  input  logic [$clog2(MAX_NODES+1)-1:0] num_nodes,
  input  logic [OP_W-1:0]                out_sel,
  input  logic                           start,
  output logic                           busy,
  output logic                           tt_valid,
  input  logic                           tt_ready,
  output logic                           tt_bit,
  output logic [NUM_IN-1:0]              tt_idx,
`ifdef MIG_TT_ONSET_EN
  output logic                           tt_last,
  output logic [NUM_IN:0]                tt_ones,
  output logic [1:0]                     tt_const
`else
  output logic                           tt_last
`endif
);

  localparam int NW     = $clog2(MAX_NODES);
  localparam int CNT_W  = $clog2(MAX_NODES + 1);
  localparam int NB     = node_base(NUM_IN);
  localparam int VEC_W  = 1 << OP_IDX_MAX;
  localparam int ONES_W = NUM_IN + 1;

  function automatic mig_op_t to_op(input logic [OP_W-1:0] raw);
    mig_op_t o;
    o.comp = raw[OP_W-1];
    o.idx  = OP_IDX_MAX'(raw[IDX_W-1:0]);
    return o;
  endfunction

  function automatic logic op_val(input mig_op_t op, input logic [VEC_W-1:0] vec);
    return op.comp ^ vec[op.idx];
  endfunction

  mig_state_e          state_q, state_d;
  logic [NW-1:0]       node_ptr_q, node_ptr_d;
  logic [CNT_W-1:0]    n_nodes_q, n_nodes_d;
  mig_op_t             out_sel_q, out_sel_d;
  logic [NUM_IN-1:0]   minterm_q, minterm_d;
  logic [MAX_NODES-1:0] res_q, res_d;
  mig_op_t             desc_q [MAX_NODES][3];
  mig_op_t             desc_d [MAX_NODES][3];
  logic                busy_q, busy_d, tt_valid_q, tt_valid_d;
  logic                tt_bit_q, tt_bit_d, tt_last_q, tt_last_d;
  logic                cfg_err_q, cfg_err_d;
`ifdef MIG_TT_ONSET_EN
  logic [ONES_W-1:0]   tt_ones_q, tt_ones_d;
  logic [1:0]          tt_const_q, tt_const_d;
`endif

  logic [OP_W-1:0]     cfg_ops [3];
  logic                wr_ok, start_bad;
  logic [VEC_W-1:0]    src_q, src_d;
  logic [2:0]          maj_val, maj_comp;
  logic                maj_y;

  // Source vectors: const 0, primary inputs, then node results.
  always_comb begin
    src_q = '0;
    src_q[CONST_IDX] = 1'b0;
    src_q[IN_BASE +: NUM_IN] = minterm_q;
    src_q[NB +: MAX_NODES] = res_q;
  end

  always_comb begin
    maj_val  = '0;
    maj_comp = '0;
    for (int i = 0; i < 3; i++) begin
      maj_val[i]  = src_q[desc_q[node_ptr_q][i].idx];
      maj_comp[i] = desc_q[node_ptr_q][i].comp;
    end
  end

  mig_maj3 u_maj3 (
    .val  (maj_val),
    .comp (maj_comp),
    .y    (maj_y)
  );

  // Node k may only see constants, inputs and lower-numbered nodes.
  always_comb begin
    cfg_ops[0] = cfg_op0;
    cfg_ops[1] = cfg_op1;
    cfg_ops[2] = cfg_op2;
    wr_ok = int'(cfg_node) < MAX_NODES;
    for (int j = 0; j < 3; j++)
      wr_ok &= int'(cfg_ops[j][IDX_W-1:0]) < NB + int'(cfg_node);
    start_bad = (int'(out_sel[IDX_W-1:0]) >= NB + int'(num_nodes)) ||
                (int'(num_nodes) > MAX_NODES);
  end

  always_comb begin
    state_d    = state_q;
    node_ptr_d = node_ptr_q;
    n_nodes_d  = n_nodes_q;
    out_sel_d  = out_sel_q;
    minterm_d  = minterm_q;
    res_d      = res_q;
    desc_d     = desc_q;
    busy_d     = busy_q;
    tt_valid_d = tt_valid_q;
    tt_last_d  = tt_last_q;
    cfg_err_d  = 1'b0;

    if (cfg_we) begin
      if (busy_q || !wr_ok) begin
        cfg_err_d = 1'b1;
      end else begin
        for (int j = 0; j < 3; j++)
          desc_d[cfg_node][j] = to_op(cfg_ops[j]);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            n_nodes_d  = num_nodes;
            out_sel_d  = to_op(out_sel);
            minterm_d  = '0;
            node_ptr_d = '0;
            busy_d     = 1'b1;
            tt_last_d  = 1'b0;
            tt_valid_d = (num_nodes == '0);
            state_d    = (num_nodes == '0) ? EMIT : EVAL;
          end
        end
      end
      EVAL: begin
        res_d[node_ptr_q] = maj_y;
        if (CNT_W'(node_ptr_q) + CNT_W'(1) == n_nodes_q) begin
          state_d    = EMIT;
          tt_valid_d = 1'b1;
          tt_last_d  = &minterm_q;
        end else begin
          node_ptr_d = node_ptr_q + NW'(1);
        end
      end
      EMIT: begin
        if (tt_ready) begin
          if (tt_last_q) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            tt_valid_d = 1'b0;
            tt_last_d  = 1'b0;
          end else begin
            minterm_d  = minterm_q + NUM_IN'(1);
            node_ptr_d = '0;
            if (n_nodes_q == '0) begin
              tt_last_d = &minterm_d;
            end else begin
              state_d    = EVAL;
              tt_valid_d = 1'b0;
              tt_last_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output bit is resolved from next-cycle results so it is registered on EMIT entry.
  always_comb begin
    src_d = '0;
    src_d[IN_BASE +: NUM_IN] = minterm_d;
    src_d[NB +: MAX_NODES] = res_d;
    tt_bit_d = tt_bit_q;
    if (state_d == EMIT)
      tt_bit_d = op_val(out_sel_d, src_d);
  end

`ifdef MIG_TT_ONSET_EN
  always_comb begin
    tt_ones_d  = tt_ones_q;
    tt_const_d = tt_const_q;
    if (state_q == IDLE && start && !start_bad) begin
      tt_ones_d  = '0;
      tt_const_d = '0;
    end
    if (state_q == EMIT && tt_ready) begin
      tt_ones_d = tt_ones_q + ONES_W'(tt_bit_q);
      if (tt_last_q)
        tt_const_d = {tt_ones_d == ONES_W'(1 << NUM_IN), tt_ones_d == '0};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      node_ptr_q <= '0;
      n_nodes_q  <= '0;
      out_sel_q  <= '0;
      minterm_q  <= '0;
      res_q      <= '0;
      busy_q     <= 1'b0;
      tt_valid_q <= 1'b0;
      tt_bit_q   <= 1'b0;
      tt_last_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int k = 0; k < MAX_NODES; k++)
        for (int j = 0; j < 3; j++)
          desc_q[k][j] <= '0;
`ifdef MIG_TT_ONSET_EN
      tt_ones_q  <= '0;
      tt_const_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      node_ptr_q <= node_ptr_d;
      n_nodes_q  <= n_nodes_d;
      out_sel_q  <= out_sel_d;
      minterm_q  <= minterm_d;
      res_q      <= res_d;
      busy_q     <= busy_d;
      tt_valid_q <= tt_valid_d;
      tt_bit_q   <= tt_bit_d;
      tt_last_q  <= tt_last_d;
      cfg_err_q  <= cfg_err_d;
      desc_q     <= desc_d;
`ifdef MIG_TT_ONSET_EN
      tt_ones_q  <= tt_ones_d;
      tt_const_q <= tt_const_d;
`endif
    end
  end

  assign cfg_err  = cfg_err_q;
  assign busy     = busy_q;
  assign tt_valid = tt_valid_q;
  assign tt_bit   = tt_bit_q;
  assign tt_idx   = minterm_q;
  assign tt_last  = tt_last_q;
`ifdef MIG_TT_ONSET_EN
  assign tt_ones  = tt_ones_q;
  assign tt_const = tt_const_q;
`endif

endmodule

// File: tb/tb_mig_tt_engine.sv
// Directed bench: a 3-input and a 7-input engine share one stimulus stream.
module tb_mig_tt_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_node = '0;
  logic [4:0] cfg_op0 = '0, cfg_op1 = '0, cfg_op2 = '0;
  logic [3:0] num_nodes = '0;
  logic [4:0] out_sel = '0;
  logic       start = 1'b0;
  logic       tt_ready = 1'b0;

  logic       a_cfg_err, a_busy, a_tt_valid, a_tt_bit, a_tt_last;
  logic [2:0] a_tt_idx;
  logic       b_cfg_err, b_busy, b_tt_valid, b_tt_bit, b_tt_last;
  logic [6:0] b_tt_idx;
`ifdef MIG_TT_ONSET_EN
  logic [3:0] a_tt_ones;
  logic [1:0] a_tt_const;
  logic [7:0] b_tt_ones;
  logic [1:0] b_tt_const;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mig_tt_engine #(.NUM_IN(3), .MAX_NODES(8)) u3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_node(cfg_node),
    .cfg_op0(cfg_op0), .cfg_op1(cfg_op1), .cfg_op2(cfg_op2), .cfg_err(a_cfg_err),
    .num_nodes(num_nodes), .out_sel(out_sel), .start(start), .busy(a_busy),
    .tt_valid(a_tt_valid), .tt_ready(tt_ready), .tt_bit(a_tt_bit), .tt_idx(a_tt_idx),
`ifdef MIG_TT_ONSET_EN
    .tt_ones(a_tt_ones), .tt_const(a_tt_const),
`endif
    .tt_last(a_tt_last)
  );

  mig_tt_engine #(.NUM_IN(7), .MAX_NODES(8)) u7 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_node(cfg_node),
    .cfg_op0(cfg_op0), .cfg_op1(cfg_op1), .cfg_op2(cfg_op2), .cfg_err(b_cfg_err),
    .num_nodes(num_nodes), .out_sel(out_sel), .start(start), .busy(b_busy),
    .tt_valid(b_tt_valid), .tt_ready(tt_ready), .tt_bit(b_tt_bit), .tt_idx(b_tt_idx),
`ifdef MIG_TT_ONSET_EN
    .tt_ones(b_tt_ones), .tt_const(b_tt_const),
`endif
    .tt_last(b_tt_last)
  );

  function automatic logic [4:0] op(input logic c, input int idx);
    return {c, 4'(idx)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cfg_write(input int node, input logic [4:0] o0, input logic [4:0] o1,
                           input logic [4:0] o2);
    cfg_we = 1'b1; cfg_node = 3'(node);
    cfg_op0 = o0; cfg_op1 = o1; cfg_op2 = o2;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int nn, input logic [4:0] sel);
    num_nodes = 4'(nn); out_sel = sel; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drains a full 128-bit stream from u7, optionally stalling 5 cycles at bp_idx.
  task automatic collect7(input int bp_idx, input logic [127:0] exp, input int exp_waits,
                          input string tag);
    logic [127:0] rx;
    int waits, seq_err, last_err, stab_err, w;
    logic hold_b;
    rx = '0; waits = 0; seq_err = 0; last_err = 0; stab_err = 0;
    tt_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      w = 0;
      while (b_tt_valid !== 1'b1 && w < 20) begin tick(); w++; end
      if (b_tt_valid !== 1'b1) begin
        chk({tag, " valid timeout"}, 32'(b_tt_valid), 1);
        return;
      end
      if (i > 0) waits += w;
      if (b_tt_idx !== 7'(i)) seq_err++;
      if (b_tt_last !== (i == 127)) last_err++;
      rx[i] = b_tt_bit;
      if (i == bp_idx) begin
        tt_ready = 1'b0;
        hold_b = b_tt_bit;
        for (int k = 0; k < 5; k++) begin
          tick();
          if (b_tt_valid !== 1'b1 || b_tt_idx !== 7'(i) || b_tt_bit !== hold_b) stab_err++;
        end
        tt_ready = 1'b1;
      end
      tick();
    end
    chk({tag, " bit errors"}, $countones(rx ^ exp), 0);
    chk({tag, " idx sequence errors"}, seq_err, 0);
    chk({tag, " tt_last errors"}, last_err, 0);
    chk({tag, " eval wait cycles"}, waits, exp_waits);
    chk({tag, " busy after last"}, 32'(b_busy), 0);
    if (bp_idx >= 0) chk({tag, " stall stability errors"}, stab_err, 0);
  endtask

  initial begin
    logic [7:0]   maj_tbl;
    logic [127:0] exp_or, exp_ones;
    logic [6:0]   m;
    int w;

    maj_tbl = 8'b1110_1000;
    exp_ones = '1;
    for (int i = 0; i < 128; i++) begin
      m = 7'(i);
      exp_or[i] = m[0] | m[1];
    end

    tick(); tick();
    rst = 1'b0;
    chk("reset busy", 32'(b_busy), 0);
    chk("reset tt_valid", 32'(b_tt_valid), 0);
    chk("reset tt_bit", 32'(b_tt_bit), 0);
    chk("reset tt_idx", 32'(b_tt_idx), 0);
    chk("reset tt_last", 32'(b_tt_last), 0);
    chk("reset cfg_err", 32'(b_cfg_err), 0);

    // 3-input majority on u3
    tt_ready = 1'b1;
    cfg_write(0, op(0, 1), op(0, 2), op(0, 3));
    chk("maj3 write err", 32'(a_cfg_err), 0);
    do_start(1, op(0, 4));
    chk("maj3 busy after start", 32'(a_busy), 1);
    chk("maj3 valid during eval", 32'(a_tt_valid), 0);
    tick();
    chk("maj3 first valid latency", 32'(a_tt_valid), 1);
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (a_tt_valid !== 1'b1 && w < 20) begin tick(); w++; end
      chk($sformatf("maj3 idx %0d", i), 32'(a_tt_idx), i);
      chk($sformatf("maj3 bit %0d", i), 32'(a_tt_bit), 32'(maj_tbl[i]));
      chk($sformatf("maj3 last %0d", i), 32'(a_tt_last), 32'(i == 7));
      if (i == 2) start = 1'b1;
      tick();
      if (i == 2) begin
        start = 1'b0;
        chk("start while busy err", 32'(a_cfg_err), 0);
      end
    end
    chk("maj3 busy falls", 32'(a_busy), 0);
`ifdef MIG_TT_ONSET_EN
    chk("maj3 tt_ones", 32'(a_tt_ones), 4);
`endif
    w = 0;
    while (b_busy !== 1'b0 && w < 400) begin tick(); w++; end
    chk("u7 sweep drains", 32'(b_busy), 0);

    rst = 1'b1; tick(); rst = 1'b0;
    tt_ready = 1'b0;

    // x0|x1 via maj(x0, x1, ~0); illegal write must leave it intact
    cfg_write(0, op(0, 1), op(0, 2), op(1, 0));
    chk("legal write err", 32'(b_cfg_err), 0);
    cfg_write(0, op(0, 8), op(0, 1), op(0, 1));
    chk("illegal write err pulse", 32'(b_cfg_err), 1);
    tick();
    chk("illegal write err clears", 32'(b_cfg_err), 0);
    do_start(0, op(0, 8));
    chk("bad out_sel err", 32'(b_cfg_err), 1);
    chk("bad out_sel stays idle", 32'(b_busy), 0);
    do_start(9, op(0, 1));
    chk("num_nodes too big err", 32'(b_cfg_err), 1);
    chk("num_nodes too big idle", 32'(b_busy), 0);
    do_start(1, op(0, 8));
    chk("or start busy", 32'(b_busy), 1);
    chk("u3 out_sel beyond nodes err", 32'(a_cfg_err), 1);
    chk("u3 out_sel beyond nodes idle", 32'(a_busy), 0);
    cfg_write(0, op(0, 3), op(0, 3), op(0, 3));
    chk("write while busy err", 32'(b_cfg_err), 1);
    collect7(2, exp_or, 127, "or sweep");

    // constant-one with no nodes: back-to-back bits
    tt_ready = 1'b1;
    do_start(0, op(1, 0));
    chk("const first valid", 32'(b_tt_valid), 1);
    collect7(-1, exp_ones, 0, "const sweep");
`ifdef MIG_TT_ONSET_EN
    chk("const tt_ones", 32'(b_tt_ones), 128);
    chk("const tt_const", 32'(b_tt_const), 2);
`endif

    // abort mid-sweep with reset
    do_start(0, op(1, 0));
    w = 0;
    while (b_tt_idx !== 7'd40 && w < 100) begin tick(); w++; end
    chk("abort reached idx 40", 32'(b_tt_idx), 40);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort busy", 32'(b_busy), 0);
    chk("abort tt_valid", 32'(b_tt_valid), 0);
    chk("abort tt_last", 32'(b_tt_last), 0);
    do_start(0, op(1, 0));
    chk("restart valid", 32'(b_tt_valid), 1);
    chk("restart idx", 32'(b_tt_idx), 0);
    chk("restart bit", 32'(b_tt_bit), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
